// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
//
// Purpose:
//   Generates VGA-style raster timing. A clock divider produces one pixel
//   advance every CLK_DIV system clocks. Column and row counters sweep the
//   full raster, including the blanking intervals. The sync and blanking
//   flags are decoded from the counters.
//
// Ports:
//   CLK         in   system clock; all state updates on its rising edge
//   RST         in   asynchronous reset, active low
//   pix_tick    out  one-CLK pulse per pixel advance
//   col         out  horizontal pixel count, 0 .. H_TOTAL-1
//   row         out  vertical line count, 0 .. V_TOTAL-1
//   hsync       out  horizontal sync, active low
//   vsync       out  vertical sync, active low
//   vnotactive  out  high while row is in vertical blanking
//   video_on    out  high inside the visible area
//   frame_start out  one-CLK pulse when the raster wraps to (0,0)
// ---------------------------------------------------------------------------
module vga_timing #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       pix_tick,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       hsync,
    output logic       vsync,
    output logic       vnotactive,
    output logic       video_on,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0] div_q, div_d;
    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic       step;
    logic       tick_q;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       vna_q, vna_d;
    logic       von_q, von_d;
    logic       fs_q, fs_d;

    // Divider and raster counters. The counters move on the same edge that
    // raises pix_tick. As a result, the cycle in which pix_tick is high is
    // also the cycle in which the new col/row first appear. Comparing with
    // '<' rather than '==' means an out-of-range count can never persist.
    always_comb begin
        step  = (div_q == DIV_LAST);
        div_d = step ? 4'd0 : div_q + 4'd1;
        col_d = col_q;
        row_d = row_q;
        if (step) begin
            if (col_q < H_LAST) begin
                col_d = col_q + 10'd1;
            end else begin
                col_d = 10'd0;
                if (row_q < V_LAST) begin
                    row_d = row_q + 10'd1;
                end else begin
                    row_d = 10'd0;
                end
            end
        end
    end

    // Flags are decoded from the next-state counters and then registered.
    // The registered flags therefore line up with the registered counters.
    always_comb begin
        hsync_d = ~((col_d >= HS_FIRST) && (col_d < HS_END));
        vsync_d = ~((row_d >= VS_FIRST) && (row_d < VS_END));
        vna_d   = (row_d >= V_VIS);
        von_d   = (col_d < H_VIS) && (row_d < V_VIS);
        fs_d    = step && (col_d == 10'd0) && (row_d == 10'd0);
    end

    // pix_tick is registered, so it stays low during reset even when
    // CLK_DIV is 1. The first tick then lands on the CLK_DIV-th edge after
    // reset is released.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_q   <= 4'd0;
            col_q   <= 10'd0;
            row_q   <= 10'd0;
            tick_q  <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            vna_q   <= 1'b0;
            von_q   <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            col_q   <= col_d;
            row_q   <= row_d;
            tick_q  <= step;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            vna_q   <= vna_d;
            von_q   <= von_d;
            fs_q    <= fs_d;
        end
    end

    assign pix_tick    = tick_q;
    assign col         = col_q;
    assign row         = row_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vnotactive  = vna_q;
    assign video_on    = von_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing
//
// Purpose:
//   Self-checking bench for vga_timing. It drives two instances:
//     A: CLK_DIV=3 with a small raster (15 x 8). A is hit with a directed
//        reset inside hsync and with randomized asynchronous resets.
//     B: CLK_DIV=1 with a 14 x 7 raster. B runs freely, and its
//        frame_start spacing is checked.
//   Expected outputs come from the number of rising edges seen since reset
//   was released, using plain integer arithmetic on the raster geometry.
// ---------------------------------------------------------------------------
module tb_vga_timing;

    localparam int A_DIV = 3;
    localparam int A_HA = 8, A_HF = 2, A_HS = 3, A_HB = 2;
    localparam int A_VA = 4, A_VF = 1, A_VS = 2, A_VB = 1;
    localparam int B_DIV = 1;
    localparam int B_HA = 8, B_HF = 2, B_HS = 2, B_HB = 2;
    localparam int B_VA = 4, B_VF = 1, B_VS = 1, B_VB = 1;

    typedef struct packed {
        logic       tick;
        logic [9:0] col;
        logic [9:0] row;
        logic       hs;
        logic       vs;
        logic       vna;
        logic       von;
        logic       fs;
    } expT;

    logic       clk = 1'b0;
    logic       rstA_n, rstB_n;
    logic       tickA, hsA, vsA, vnaA, vonA, fsA;
    logic [9:0] colA, rowA;
    logic       tickB, hsB, vsB, vnaB, vonB, fsB;
    logic [9:0] colB, rowB;

    int  compareCount  = 0;
    int  mismatchCount = 0;
    int  kA = 0;
    int  kB = 0;
    int  lastFsB = -1;
    int  tickCountA = 0;
    int  frameCountA = 0;
    bit  checkEn = 1'b0;

    vga_timing #(
        .CLK_DIV(A_DIV), .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB)
    ) dutA (
        .CLK(clk), .RST(rstA_n), .pix_tick(tickA), .col(colA), .row(rowA),
        .hsync(hsA), .vsync(vsA), .vnotactive(vnaA), .video_on(vonA),
        .frame_start(fsA)
    );

    vga_timing #(
        .CLK_DIV(B_DIV), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB)
    ) dutB (
        .CLK(clk), .RST(rstB_n), .pix_tick(tickB), .col(colB), .row(rowB),
        .hsync(hsB), .vsync(vsB), .vnotactive(vnaB), .video_on(vonB),
        .frame_start(fsB)
    );

    // 10-unit clock period. Rising edges fall at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Count the rising edges each instance has seen since its reset was
    // released. An asserted reset zeroes the count at once.
    always @(posedge clk or negedge rstA_n) begin
        if (!rstA_n) kA <= 0;
        else         kA <= kA + 1;
    end

    always @(posedge clk or negedge rstB_n) begin
        if (!rstB_n) kB <= 0;
        else         kB <= kB + 1;
    end

    // Reference model. After k edges the pixel index is k/div, and the raster
    // position, sync windows and frame pulses all follow from that index.
    function automatic expT refModel(input int k, input int d,
                                     input int ha, input int hf, input int hs, input int hb,
                                     input int va, input int vf, input int vs, input int vb);
        expT e;
        int  ht, vt, p, c, r;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        p  = k / d;
        c  = p % ht;
        r  = (p / ht) % vt;
        e.tick = (k > 0) && (k % d == 0);
        e.col  = 10'(c);
        e.row  = 10'(r);
        e.hs   = !((c >= ha + hf) && (c < ha + hf + hs));
        e.vs   = !((r >= va + vf) && (r < va + vf + vs));
        e.vna  = (r >= va);
        e.von  = (c < ha) && (r < va);
        e.fs   = e.tick && (p % (ht * vt) == 0);
        return e;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Checks all outputs of one instance against an expected record.
    task automatic checkInstance(input string who, input expT e,
                                 input logic tick, input logic [9:0] c, input logic [9:0] r,
                                 input logic hs, input logic vs, input logic vna,
                                 input logic von, input logic fs);
        checkOutput({who, ".pix_tick"},    32'(tick), 32'(e.tick));
        checkOutput({who, ".col"},         32'(c),    32'(e.col));
        checkOutput({who, ".row"},         32'(r),    32'(e.row));
        checkOutput({who, ".hsync"},       32'(hs),   32'(e.hs));
        checkOutput({who, ".vsync"},       32'(vs),   32'(e.vs));
        checkOutput({who, ".vnotactive"},  32'(vna),  32'(e.vna));
        checkOutput({who, ".video_on"},    32'(von),  32'(e.von));
        checkOutput({who, ".frame_start"}, 32'(fs),   32'(e.fs));
    endtask

    function automatic expT modelA(input int k);
        return refModel(k, A_DIV, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB);
    endfunction

    function automatic expT modelB(input int k);
        return refModel(k, B_DIV, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB);
    endfunction

    // Every falling edge, compare both instances against the model. Also
    // track A's tick and frame counts and B's frame_start spacing.
    always @(negedge clk) begin
        if (checkEn) begin
            checkInstance("A", modelA(kA), tickA, colA, rowA, hsA, vsA, vnaA, vonA, fsA);
            checkInstance("B", modelB(kB), tickB, colB, rowB, hsB, vsB, vnaB, vonB, fsB);
            if (tickA === 1'b1) tickCountA++;
            if (fsA === 1'b1)   frameCountA++;
            if (fsB === 1'b1) begin
                if (lastFsB >= 0) checkOutput("B.fsSpacing", 32'(kB - lastFsB), 32'd98);
                lastFsB = kB;
            end
        end
    end

    // Run A for a while, then assert its reset at a random point mid-cycle.
    // The outputs must drop to reset values before the next rising edge.
    task automatic applyStimulus(input int runCycles, input int holdCycles);
        repeat (runCycles) @(negedge clk);
        #($urandom_range(1, 3));
        rstA_n = 1'b0;
        #1;
        checkInstance("A.asyncRand", modelA(0), tickA, colA, rowA, hsA, vsA, vnaA, vonA, fsA);
        repeat (holdCycles) @(negedge clk);
        #2;
        rstA_n = 1'b1;
    endtask

    initial begin
        bit found;
        rstA_n = 1'b1;
        rstB_n = 1'b1;
        #1;
        rstA_n = 1'b0;
        rstB_n = 1'b0;
        #1;
        $display("[TB] checking reset state");
        checkInstance("A.reset", modelA(0), tickA, colA, rowA, hsA, vsA, vnaA, vonA, fsA);
        checkInstance("B.reset", modelB(0), tickB, colB, rowB, hsB, vsB, vnaB, vonB, fsB);
        checkEn = 1'b1;

        @(negedge clk);
        #2;
        rstA_n = 1'b1;
        rstB_n = 1'b1;
        tickCountA  = 0;
        frameCountA = 0;

        // Two full frames of A: 15*8 pixels * 3 clocks per pixel * 2 frames.
        repeat (720) @(negedge clk);
        #1;
        checkOutput("A.tickCount2Frames",  32'(tickCountA),  32'd240);
        checkOutput("A.frameCount2Frames", 32'(frameCountA), 32'd2);

        // Directed: reset A at row 2, col 11, which lies inside hsync.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            #1;
            if (modelA(kA).row == 10'd2 && modelA(kA).col == 10'd11) found = 1'b1;
        end
        if (!found) checkOutput("A.waitHsync", 32'd0, 32'd1);
        checkOutput("A.preResetHsync", 32'(hsA), 32'd0);
        #1;
        rstA_n = 1'b0;
        #1;
        checkInstance("A.asyncHsync", modelA(0), tickA, colA, rowA, hsA, vsA, vnaA, vonA, fsA);
        repeat (3) @(negedge clk);
        #2;
        rstA_n = 1'b1;

        for (int n = 0; n < 5; n++) begin
            applyStimulus(int'($urandom_range(20, 800)), int'($urandom_range(1, 4)));
        end

        repeat (400) @(negedge clk);
        #1;
        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
